sonata_in_pin_filter: RTL and testbench

- Input-side companion to the pinmux output path.
- Takes raw board input pins (ser RX, RS232 RX, SPI CIPO, mikroBUS, microSD DAT0) and produces clean synchronised levels plus sticky per-pin edge events and an interrupt.
- Sits between the top-level input pads and the pinmux/GPIO input consumers.
- Per pin it provides a 2-flop synchroniser, an optional glitch filter, edge detection and a write-1-to-clear event register.

---
 rtl/sonata_in_pin_filter.sv | 91 +++++++++
 tb/tb_sonata_in_pin_filter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sonata_in_pin_filter.sv
// Input pin conditioning: 2-flop synchroniser, optional per-pin glitch filter,
// edge detection on the clean level and sticky write-1-to-clear edge events.
module sonata_in_pin_filter #(
    parameter int unsigned NumPins      = 8,
    parameter int unsigned FilterCycles = 4,
    localparam int unsigned CntW        = $clog2(FilterCycles + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumPins-1:0] pins_i,
    input  logic [NumPins-1:0] filter_en_i,
    input  logic [NumPins-1:0] rise_en_i,
    input  logic [NumPins-1:0] fall_en_i,
    input  logic [NumPins-1:0] clear_i,
    output logic [NumPins-1:0] pins_o,
    output logic [NumPins-1:0] event_o,
    output logic               irq_o
);

    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

    logic [NumPins-1:0] s1_q, s2_q;
    logic [NumPins-1:0] cand_q, cand_d;
    logic [CntW-1:0]    cnt_q [NumPins];
    logic [CntW-1:0]    cnt_d [NumPins];
    logic [NumPins-1:0] pins_q, pins_d;
    logic [NumPins-1:0] prev_q;
    logic [NumPins-1:0] event_q, event_d;
    logic               irq_q;
    logic [NumPins-1:0] rise, fall;

    // Candidate tracking runs even when the filter is disabled, so enabling
    // it later picks up from the current stable history.
    always_comb begin
        cand_d = cand_q;
        pins_d = pins_q;
        for (int i = 0; i < NumPins; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] != cand_q[i]) begin
                cand_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else if (cnt_q[i] < CntMax) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            if (!filter_en_i[i]) begin
                pins_d[i] = s2_q[i];
            end else if ((s2_q[i] == cand_q[i]) && (cnt_q[i] == CntMax)) begin
                pins_d[i] = cand_q[i];
            end
        end
    end

    always_comb begin
        rise    = ~prev_q & pins_q;
        fall    = prev_q & ~pins_q;
        // Set has priority over a same-cycle clear.
        event_d = (event_q & ~clear_i) | (rise & rise_en_i) | (fall & fall_en_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            pins_q  <= '0;
            prev_q  <= '0;
            event_q <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NumPins; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= pins_i;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            pins_q  <= pins_d;
            prev_q  <= pins_q;
            event_q <= event_d;
            irq_q   <= |event_d;
            for (int i = 0; i < NumPins; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pins_o  = pins_q;
    assign event_o = event_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_sonata_in_pin_filter.sv
// Directed bench for sonata_in_pin_filter: latency, glitch filter, edge
// events, set/clear priority and asynchronous reset.
module tb_sonata_in_pin_filter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] pins_i, filter_en_i, rise_en_i, fall_en_i, clear_i;
    logic [7:0] pins_o, event_o;
    logic       irq_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    sonata_in_pin_filter #(
        .NumPins      (8),
        .FilterCycles (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pins_i      (pins_i),
        .filter_en_i (filter_en_i),
        .rise_en_i   (rise_en_i),
        .fall_en_i   (fall_en_i),
        .clear_i     (clear_i),
        .pins_o      (pins_o),
        .event_o     (event_o),
        .irq_o       (irq_o)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_clear(input logic [7:0] mask);
        clear_i = mask;
        step(1);
        clear_i = '0;
    endtask

    initial begin
        rst_ni      = 1'b0;
        pins_i      = 8'hFF;
        filter_en_i = 8'h00;
        rise_en_i   = 8'hFF;
        fall_en_i   = 8'h00;
        clear_i     = 8'h00;

        // Reset with all pins high
        step(2);
        check_eq("rst_pins", pins_o, 8'h00);
        check_eq("rst_event", event_o, 8'h00);
        check_eq("rst_irq", {7'b0, irq_o}, 8'h00);
        rst_ni = 1'b1;
        step(2);
        check_eq("rel_pins_e2", pins_o, 8'h00);
        step(1);
        check_eq("rel_pins_e3", pins_o, 8'hFF);
        check_eq("rel_event_e3", event_o, 8'h00);
        step(1);
        check_eq("rel_event_e4", event_o, 8'hFF);
        check_eq("rel_irq_e4", {7'b0, irq_o}, 8'h01);
        pulse_clear(8'hFF);
        check_eq("clrall_event", event_o, 8'h00);
        check_eq("clrall_irq", {7'b0, irq_o}, 8'h00);
        pins_i = 8'h00;
        step(5);
        check_eq("low_pins", pins_o, 8'h00);
        check_eq("low_no_fall_event", event_o, 8'h00);

        // Unfiltered latency on pin 3
        pins_i = 8'h08;
        step(2);
        check_eq("unf_pins_e2", pins_o, 8'h00);
        step(1);
        check_eq("unf_pins_e3", pins_o, 8'h08);
        check_eq("unf_event_e3", event_o, 8'h00);
        step(1);
        check_eq("unf_event_e4", event_o, 8'h08);
        check_eq("unf_irq_e4", {7'b0, irq_o}, 8'h01);
        pulse_clear(8'h08);
        check_eq("unf_clr_event", event_o, 8'h00);
        check_eq("unf_clr_irq", {7'b0, irq_o}, 8'h00);
        pins_i = 8'h00;
        step(5);
        check_eq("unf_back_low", pins_o, 8'h00);

        // Glitch filter on pin 0: 4-cycle pulse rejected
        filter_en_i = 8'h01;
        pins_i = 8'h01;
        step(4);
        pins_i = 8'h00;
        step(10);
        check_eq("glitch4_pins", pins_o, 8'h00);
        check_eq("glitch4_event", event_o, 8'h00);

        // 5-cycle pulse passes after edge 7
        pins_i = 8'h01;
        step(5);
        pins_i = 8'h00;
        step(1);
        check_eq("pulse5_pins_e6", pins_o, 8'h00);
        step(1);
        check_eq("pulse5_pins_e7", pins_o, 8'h01);
        step(1);
        check_eq("pulse5_event_e8", event_o, 8'h01);
        step(3);
        check_eq("pulse5_pins_e11", pins_o, 8'h01);
        step(1);
        check_eq("pulse5_pins_e12", pins_o, 8'h00);
        pulse_clear(8'h01);
        check_eq("pulse5_clr", event_o, 8'h00);
        filter_en_i = 8'h00;

        // Falling edge only on pin 5
        rise_en_i = 8'h00;
        fall_en_i = 8'h20;
        pins_i = 8'h20;
        step(6);
        check_eq("fall_high_pins", pins_o, 8'h20);
        check_eq("fall_no_rise_evt", event_o, 8'h00);
        pins_i = 8'h00;
        step(3);
        check_eq("fall_low_pins", pins_o, 8'h00);
        check_eq("fall_evt_e3", event_o, 8'h00);
        step(1);
        check_eq("fall_evt_e4", event_o, 8'h20);
        check_eq("fall_irq_e4", {7'b0, irq_o}, 8'h01);
        pulse_clear(8'h20);
        check_eq("fall_clr", event_o, 8'h00);

        // Set and clear in the same cycle on pin 2
        rise_en_i = 8'h04;
        fall_en_i = 8'h00;
        pins_i = 8'h04;
        step(4);
        check_eq("sc_first_evt", event_o, 8'h04);
        pins_i = 8'h00;
        step(4);
        check_eq("sc_low_pins", pins_o, 8'h00);
        pins_i = 8'h04;
        step(3);
        check_eq("sc_pins_e3", pins_o, 8'h04);
        clear_i = 8'h04;
        step(1);
        clear_i = 8'h00;
        check_eq("sc_evt_kept", event_o, 8'h04);
        check_eq("sc_irq_kept", {7'b0, irq_o}, 8'h01);
        pulse_clear(8'h04);
        check_eq("sc_evt_cleared", event_o, 8'h00);
        check_eq("sc_irq_cleared", {7'b0, irq_o}, 8'h00);
        pins_i = 8'h00;
        step(4);

        // Reset mid-filter: pin 0 filtered (cnt=2), pin 1 unfiltered
        filter_en_i = 8'h01;
        rise_en_i = 8'h03;
        pins_i = 8'h03;
        step(5);
        check_eq("mid_pins_pre", pins_o, 8'h02);
        check_eq("mid_event_pre", event_o, 8'h02);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_pins", pins_o, 8'h00);
        check_eq("mid_rst_event", event_o, 8'h00);
        check_eq("mid_rst_irq", {7'b0, irq_o}, 8'h00);
        step(1);
        rst_ni = 1'b1;
        step(3);
        check_eq("mid_rel_pins_e3", pins_o, 8'h02);
        step(1);
        check_eq("mid_rel_evt_e4", event_o, 8'h02);
        step(2);
        check_eq("mid_rel_pins_e6", pins_o, 8'h02);
        step(1);
        check_eq("mid_rel_pins_e7", pins_o, 8'h03);
        check_eq("mid_rel_evt_e7", event_o, 8'h02);
        step(1);
        check_eq("mid_rel_evt_e8", event_o, 8'h03);
        check_eq("mid_rel_irq_e8", {7'b0, irq_o}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
